mult_flux_scheduler: RTL
========================

Name: mult_flux_scheduler

Overview:
- Round-robin scheduler and sequencer for the shared multi-flux scalar-multiply actor of the HEVC dataflow.
- Each cycle it picks at most one flux (tag) whose FIFOs allow progress and issues one datapath command for that flux:
  - config load: consume coefficient plus block size;
  - multiply: consume one operand, write one product.
- Per flux it tracks block position (h/v counters) and raises first/last markers.
- It replaces fixed lowest-tag priority with fair arbitration.

Parameters:
FLUX, 2, number of interleaved data fluxes; TAG_WIDTH = $clog2(FLUX), minimum 1
SIZE_WIDTH, 7, width of block-size field N (block is N x N elements)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_empty  in  FLUX  per-flux empty of coefficient FIFO and ext_size FIFO (ANDed upstream)
cfg_size  in  FLUX*SIZE_WIDTH  per-flux head of ext_size FIFO, flux i at [i*SIZE_WIDTH +: SIZE_WIDTH]
data_empty  in  FLUX  per-flux empty of operand-A FIFO
out_full  in  1  full of shared output FIFO
cfg_read  out  FLUX  one-hot pop of config FIFOs (coefficient and size together)
data_read  out  FLUX  one-hot pop of operand-A FIFO
dp_tag  out  TAG_WIDTH  selected flux; drives datapath coefficient-register index and output tag
dp_load  out  1  datapath latches coefficient for dp_tag
dp_mul  out  1  datapath multiplies and writes output (= output FIFO write)
dp_first  out  1  with dp_mul: element (0,0) of the block
dp_last  out  1  with dp_mul: final element of the block
size_err  out  1  one-cycle pulse: config with N==0 was consumed
busy  out  FLUX  flux i in WORK state

Behaviour:
- Per-flux registers: state (IDLE/WORK), max (N-1), cnt_h, cnt_v (SIZE_WIDTH bits each).
- Round-robin pointer rr (TAG_WIDTH).
- Reset:
  - all states IDLE; max, cnt_h, cnt_v = 0;
  - rr = FLUX-1, so tag 0 has first priority after reset;
  - size_err = 0.
- Eligibility of flux i:
  - IDLE: !cfg_empty[i];
  - WORK: !data_empty[i] && !out_full.
- Grant:
  - combinational; first eligible flux scanning rr+1, rr+2, ... modulo FLUX;
  - no eligible flux: all read/dp strobes 0, dp_tag = 0.
- rr update: rr <= granted tag at the clock edge of every grant; otherwise unchanged.
- IDLE grant:
  - cfg_read[g] = 1, dp_load = 1;
  - N != 0: max[g] <= N-1, cnt_h/cnt_v <= 0, state <= WORK.
  - N == 0: config still popped, dp_load = 0, state stays IDLE, size_err pulses the next cycle (registered).
- WORK grant:
  - data_read[g] = 1, dp_mul = 1;
  - dp_first = (cnt_h==0 && cnt_v==0);
  - dp_last = (cnt_h==max && cnt_v==max).
- Counter update on a WORK grant:
  - cnt_h < max: cnt_h++;
  - cnt_h == max, cnt_v < max: cnt_h <= 0, cnt_v++;
  - both == max: both <= 0, state <= IDLE.
  - Total of N*N multiplies per config.
- N = 1 gives a single multiply with dp_first = dp_last = 1.
- Timing:
  - strobes are same-cycle combinational (zero latency);
  - register updates occur on the granting edge;
  - a flux returning to IDLE may reload config on the very next cycle if granted.
- out_full high:
  - blocks all WORK fluxes;
  - IDLE fluxes may still load config.
- Only one strobe class is active per cycle; at most one bit of cfg_read|data_read is set.
- Non-granted fluxes keep all their registers.
- Maximum N = 2^SIZE_WIDTH - 1; N-1 always fits.
- rst mid-block:
  - discards per-flux progress and forces all fluxes to IDLE next cycle;
  - FIFO contents are untouched (the upstream reset is responsible for them).
- Strobes depend only on registered state and the current empty/full flags; no combinational loop through dp_*.

Optional Feature:
- Macro MULT_SCHED_PERF_EN.
- When defined:
  - extra outputs blk_done (FLUX*16) and stall_cyc (16) are present;
  - blk_done[i] increments on each dp_last for flux i;
  - stall_cyc increments each cycle some WORK flux has !data_empty while out_full = 1;
  - all counters saturate at 16'hFFFF and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. FLUX=2, flux0 config N=2, four operands, out_full=0:
   - cycle 0: cfg_read=01, dp_load=1, dp_tag=0;
   - then 4 dp_mul pulses, first with dp_first=1 and fourth with dp_last=1;
   - busy[0] returns to 0 after the fourth.
2. Both fluxes configured N=3 with operands always present:
   - grants alternate 0,1,0,1...;
   - each flux gets exactly 9 dp_mul, with dp_last on its 9th.
3. Flux0 in WORK, out_full=1 for 5 cycles while flux1 has pending config:
   - only flux1 cfg_read/dp_load occur;
   - no dp_mul or data_read during the stall;
   - flux0 counters unchanged, then it resumes.
4. Config N=0 on flux1:
   - cfg_read=10 for one cycle, dp_load=0;
   - size_err=1 the next cycle; busy[1] stays 0.
5. Config N=1: one dp_mul with dp_first=dp_last=1; the flux is immediately IDLE and accepts the next config the following cycle.
6. rst asserted after 5 of 9 elements (N=3):
   - busy=0 next cycle;
   - a new N=2 config then yields exactly 4 multiplies starting with dp_first=1.
   - With MULT_SCHED_PERF_EN: blk_done = 0 after the reset.

Source files
------------

// File: rtl/mult_flux_scheduler.sv
// mult_flux_scheduler: round-robin command sequencer for the shared
// multi-flux scalar multiplier; optional counters under MULT_SCHED_PERF_EN.
module mult_flux_scheduler #(
   parameter int FLUX       = 2,
   parameter int SIZE_WIDTH = 7,
   localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FLUX-1:0]            cfg_empty,
   input  logic [FLUX*SIZE_WIDTH-1:0] cfg_size,
   input  logic [FLUX-1:0]            data_empty,
   input  logic                       out_full,
   output logic [FLUX-1:0]            cfg_read,
   output logic [FLUX-1:0]            data_read,
   output logic [TAG_WIDTH-1:0]       dp_tag,
   output logic                       dp_load,
   output logic                       dp_mul,
   output logic                       dp_first,
   output logic                       dp_last,
   output logic                       size_err,
   output logic [FLUX-1:0]            busy
`ifdef MULT_SCHED_PERF_EN
   ,
   output logic [FLUX*16-1:0]         blk_done,
   output logic [15:0]                stall_cyc
`endif
);

   typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_t;

   state_t                state_q [FLUX];
   state_t                state_d [FLUX];
   logic [SIZE_WIDTH-1:0] max_q   [FLUX];
   logic [SIZE_WIDTH-1:0] max_d   [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_h_q [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_h_d [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_v_q [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_v_d [FLUX];
   logic [SIZE_WIDTH-1:0] size_a  [FLUX];
   logic [TAG_WIDTH-1:0]  rr_q, rr_d, gnt, idx;
   logic [FLUX-1:0]       elig;
   logic                  found, size_err_d;

   // per-flux size unpacking, busy flags and eligibility
   always_comb begin
      for (int i = 0; i < FLUX; i++) begin
         size_a[i] = cfg_size[i*SIZE_WIDTH +: SIZE_WIDTH];
         busy[i]   = (state_q[i] == WORK);
         elig[i]   = (state_q[i] == WORK) ? (!data_empty[i] && !out_full)
                                          : !cfg_empty[i];
      end
   end

   // round-robin scan starting just after the last granted tag
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = rr_q;
      for (int k = 0; k < FLUX; k++) begin
         idx = (idx == TAG_WIDTH'(FLUX - 1)) ? '0 : idx + TAG_WIDTH'(1);
         if (!found && elig[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   // command strobes and next-state for the granted flux
   always_comb begin
      cfg_read   = '0;
      data_read  = '0;
      dp_tag     = '0;
      dp_load    = 1'b0;
      dp_mul     = 1'b0;
      dp_first   = 1'b0;
      dp_last    = 1'b0;
      size_err_d = 1'b0;
      rr_d       = rr_q;
      state_d    = state_q;
      max_d      = max_q;
      cnt_h_d    = cnt_h_q;
      cnt_v_d    = cnt_v_q;
      if (found) begin
         dp_tag = gnt;
         rr_d   = gnt;
         if (state_q[gnt] == WORK) begin
            data_read[gnt] = 1'b1;
            dp_mul   = 1'b1;
            dp_first = (cnt_h_q[gnt] == '0) && (cnt_v_q[gnt] == '0);
            dp_last  = (cnt_h_q[gnt] == max_q[gnt]) &&
                       (cnt_v_q[gnt] == max_q[gnt]);
            if (cnt_h_q[gnt] < max_q[gnt]) begin
               cnt_h_d[gnt] = cnt_h_q[gnt] + SIZE_WIDTH'(1);
            end else if (cnt_v_q[gnt] < max_q[gnt]) begin
               cnt_h_d[gnt] = '0;
               cnt_v_d[gnt] = cnt_v_q[gnt] + SIZE_WIDTH'(1);
            end else begin
               cnt_h_d[gnt] = '0;
               cnt_v_d[gnt] = '0;
               state_d[gnt] = IDLE;
            end
         end else begin
            cfg_read[gnt] = 1'b1;
            if (size_a[gnt] != '0) begin
               dp_load      = 1'b1;
               max_d[gnt]   = size_a[gnt] - SIZE_WIDTH'(1);
               cnt_h_d[gnt] = '0;
               cnt_v_d[gnt] = '0;
               state_d[gnt] = WORK;
            end else begin
               size_err_d = 1'b1;
            end
         end
      end
   end

   // state registers; reset leaves tag 0 first in line
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FLUX; i++) begin
            state_q[i] <= IDLE;
            max_q[i]   <= '0;
            cnt_h_q[i] <= '0;
            cnt_v_q[i] <= '0;
         end
         rr_q     <= TAG_WIDTH'(FLUX - 1);
         size_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         max_q    <= max_d;
         cnt_h_q  <= cnt_h_d;
         cnt_v_q  <= cnt_v_d;
         rr_q     <= rr_d;
         size_err <= size_err_d;
      end
   end

`ifdef MULT_SCHED_PERF_EN
   logic [15:0] blk_q [FLUX];
   logic        stall_hit;

   // a stall is a WORK flux holding an operand while the output is full
   always_comb begin
      stall_hit = out_full && |(busy & ~data_empty);
      for (int i = 0; i < FLUX; i++) begin
         blk_done[i*16 +: 16] = blk_q[i];
      end
   end

   // saturating block-completion and stall counters
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FLUX; i++) begin
            blk_q[i] <= '0;
         end
         stall_cyc <= '0;
      end else begin
         for (int i = 0; i < FLUX; i++) begin
            if (dp_last && (dp_tag == TAG_WIDTH'(i)) && (blk_q[i] != 16'hFFFF))
               blk_q[i] <= blk_q[i] + 16'd1;
         end
         if (stall_hit && (stall_cyc != 16'hFFFF))
            stall_cyc <= stall_cyc + 16'd1;
      end
   end
`endif

endmodule
